// File: rtl/ai_i2s_wb_pkg.sv
// Shared types and constants for the I2S Wishbone arbiter slice.
//   arb_state_t : arbiter FSM states
//   core_idx_t  : index of the four I2S sub-cores behind the arbiter
//   CTI_*/BTE_* : Wishbone cycle-type / burst-type encodings
//   core_onehot : converts a core index into its one-hot strobe vector
package ai_i2s_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        CORE_TXM = 2'd0,
        CORE_TXS = 2'd1,
        CORE_RXM = 2'd2,
        CORE_RXS = 2'd3
    } core_idx_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic logic [3:0] core_onehot(input logic [1:0] idx);
        core_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ai_i2s_wb_decoder.sv
// Combinational address decoder for the I2S Wishbone arbiter.
// Splits a Wishbone byte address into a sub-core index and a register
// offset, and flags accesses that must be answered with an error.
//   adr_i  in  32      Wishbone byte address
//   cti_i  in  3       Wishbone cycle type
//   bte_i  in  2       Wishbone burst type
//   hit_o  out 1       1 = access maps onto a sub-core and may proceed
//   idx_o  out 2       selected sub-core (0 txm, 1 txs, 2 rxm, 3 rxs)
//   reg_o  out REG_AW  word offset inside the selected sub-core
module ai_i2s_wb_decoder
    import ai_i2s_wb_pkg::*;
#(
    parameter int SEL_LSB = 6,
    parameter int REG_AW  = 4
) (
    input  logic [31:0]       adr_i,
    input  logic [2:0]        cti_i,
    input  logic [1:0]        bte_i,
    output logic              hit_o,
    output logic [1:0]        idx_o,
    output logic [REG_AW-1:0] reg_o
);

    logic addr_miss;
    logic burst_bad;

    // The byte-lane bits never take part in the decode.
    logic unused_adr;
    assign unused_adr = ^adr_i[1:0];

    // Anything above the core-select field must be zero, otherwise the
    // address lies outside the register window of the four sub-cores.
    assign addr_miss = (adr_i[31:SEL_LSB+2] != '0);

    // Only linear incrementing bursts are understood; wrap modes are refused.
    // The burst type is meaningless for classic and end-of-burst cycles.
    assign burst_bad = (cti_i == CTI_INCR) && (bte_i != BTE_LINEAR);

    assign hit_o = !addr_miss && !burst_bad;
    assign idx_o = adr_i[SEL_LSB+1:SEL_LSB];
    assign reg_o = adr_i[REG_AW+1:2];

endmodule

// File: rtl/ai_i2s_wb_arbiter.sv
// Wishbone slave front-end sharing one I2S register port among four
// sub-cores (TX master, TX slave, RX master, RX slave). Each Wishbone
// beat is decoded to one sub-core, forwarded as a held strobe until the
// sub-core acks, then answered with a one-cycle ack (with read data) or,
// on a decode miss / missing ack, a one-cycle error.
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i    Wishbone request
//   wb_cyc_i/stb_i/cti_i/bte_i   Wishbone cycle control
//   wb_dat_o/ack_o/err_o         Wishbone response
//   sub_stb_o                    one-hot strobe towards the sub-cores
//   sub_we_o/sel_o/adr_o/dat_o   latched request towards the sub-cores
//   sub_dat_i                    packed read data, 32 bits per sub-core
//   txm_ack..rxs_ack             per-core acknowledge
//   err_cnt_o                    saturating count of error responses
module ai_i2s_wb_arbiter
    import ai_i2s_wb_pkg::*;
#(
    parameter int SEL_LSB = 6,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [3:0]        sub_stb_o,
    output logic              sub_we_o,
    output logic              sub_sel_o,
    output logic [REG_AW-1:0] sub_adr_o,
    output logic [31:0]       sub_dat_o,
    input  logic [127:0]      sub_dat_i,
    input  logic              txm_ack,
    input  logic              txs_ack,
    input  logic              rxm_ack,
    input  logic              rxs_ack,
    output logic [7:0]        err_cnt_o
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        sub_stb_q, sub_stb_d;
    logic              sub_we_q, sub_we_d;
    logic              sub_sel_q, sub_sel_d;
    logic [REG_AW-1:0] sub_adr_q, sub_adr_d;
    logic [31:0]       sub_dat_q, sub_dat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              dec_hit;
    logic [1:0]        dec_idx;
    logic [REG_AW-1:0] dec_reg;

    logic              sel_ack;
    logic [31:0]       sel_dat;
    logic [7:0]        err_cnt_inc;

    ai_i2s_wb_decoder #(
        .SEL_LSB (SEL_LSB),
        .REG_AW  (REG_AW)
    ) u_decoder (
        .adr_i (wb_adr_i),
        .cti_i (wb_cti_i),
        .bte_i (wb_bte_i),
        .hit_o (dec_hit),
        .idx_o (dec_idx),
        .reg_o (dec_reg)
    );

    // Only the ack and read-data slice of the core latched for the current
    // transfer matter; acks from the other cores are simply not looked at.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = 32'h0;
        case (core_idx_t'(idx_q))
            CORE_TXM: begin sel_ack = txm_ack; sel_dat = sub_dat_i[31:0];   end
            CORE_TXS: begin sel_ack = txs_ack; sel_dat = sub_dat_i[63:32];  end
            CORE_RXM: begin sel_ack = rxm_ack; sel_dat = sub_dat_i[95:64];  end
            CORE_RXS: begin sel_ack = rxs_ack; sel_dat = sub_dat_i[127:96]; end
            default:  begin sel_ack = 1'b0;    sel_dat = 32'h0;             end
        endcase
    end

    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    // Next-state and registered-output logic. Ack/err are registered so they
    // can only ever be set on the transition into ACK or ERR, which makes
    // them mutually exclusive and exactly one cycle long.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sub_stb_d = sub_stb_q;
        sub_we_d  = sub_we_q;
        sub_sel_d = sub_sel_q;
        sub_adr_d = sub_adr_q;
        sub_dat_d = sub_dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdat_d    = 32'h0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                sub_stb_d = 4'b0000;
                if (wb_cyc_i && wb_stb_i) begin
                    idx_d     = dec_idx;
                    sub_we_d  = wb_we_i;
                    sub_sel_d = wb_sel_i;
                    sub_adr_d = dec_reg;
                    sub_dat_d = wb_dat_i;
                    if (dec_hit) begin
                        state_d   = REQ;
                        sub_stb_d = core_onehot(dec_idx);
                    end else begin
                        state_d   = ERR;
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_inc;
                    end
                end
            end

            // An abandoned cycle is dropped silently; a real ack beats the
            // timeout even when both land on the same edge.
            REQ: begin
                if (!wb_cyc_i) begin
                    state_d   = IDLE;
                    sub_stb_d = 4'b0000;
                end else if (sel_ack) begin
                    state_d   = ACK;
                    sub_stb_d = 4'b0000;
                    ack_d     = 1'b1;
                    rdat_d    = sub_we_q ? 32'h0 : sel_dat;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ERR;
                    sub_stb_d = 4'b0000;
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_inc;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                sub_stb_d = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 2'b00;
            sub_stb_q <= 4'b0000;
            sub_we_q  <= 1'b0;
            sub_sel_q <= 1'b0;
            sub_adr_q <= '0;
            sub_dat_q <= 32'h0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= 32'h0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sub_stb_q <= sub_stb_d;
            sub_we_q  <= sub_we_d;
            sub_sel_q <= sub_sel_d;
            sub_adr_q <= sub_adr_d;
            sub_dat_q <= sub_dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign sub_stb_o = sub_stb_q;
    assign sub_we_o  = sub_we_q;
    assign sub_sel_o = sub_sel_q;
    assign sub_adr_o = sub_adr_q;
    assign sub_dat_o = sub_dat_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ai_i2s_wb_arbiter.sv
// Directed testbench for ai_i2s_wb_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge; the arbiter works on the rising edge.
// Core select is wb_adr_i[7:6] and register offset is wb_adr_i[5:2].
module tb_ai_i2s_wb_arbiter;
    import ai_i2s_wb_pkg::*;

    logic         wb_clk_i;
    logic         wb_rst_i;
    logic [31:0]  wb_adr_i;
    logic [31:0]  wb_dat_i;
    logic         wb_sel_i;
    logic         wb_we_i;
    logic         wb_cyc_i;
    logic         wb_stb_i;
    logic [2:0]   wb_cti_i;
    logic [1:0]   wb_bte_i;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic         wb_err_o;
    logic [3:0]   sub_stb_o;
    logic         sub_we_o;
    logic         sub_sel_o;
    logic [3:0]   sub_adr_o;
    logic [31:0]  sub_dat_o;
    logic [127:0] sub_dat_i;
    logic         txm_ack;
    logic         txs_ack;
    logic         rxm_ack;
    logic         rxs_ack;
    logic [7:0]   err_cnt_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n;
    int   stb_cycles;
    int   ack_count;
    logic got_err;
    logic got_ack;

    ai_i2s_wb_arbiter #(
        .SEL_LSB (6),
        .REG_AW  (4),
        .TIMEOUT (16)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cti_i  (wb_cti_i),
        .wb_bte_i  (wb_bte_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .sub_stb_o (sub_stb_o),
        .sub_we_o  (sub_we_o),
        .sub_sel_o (sub_sel_o),
        .sub_adr_o (sub_adr_o),
        .sub_dat_o (sub_dat_o),
        .sub_dat_i (sub_dat_i),
        .txm_ack   (txm_ack),
        .txs_ack   (txs_ack),
        .rxm_ack   (rxm_ack),
        .rxs_ack   (rxs_ack),
        .err_cnt_o (err_cnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Safety net so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                 input logic [2:0] cti, input logic [1:0] bte);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_dat_i = dat;
        wb_sel_i = 1'b1;
        wb_cti_i = cti;
        wb_bte_i = bte;
    endtask

    task automatic endCycle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_cti_i = CTI_CLASSIC;
        wb_bte_i = BTE_LINEAR;
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        wb_adr_i  = 32'h0;
        wb_dat_i  = 32'h0;
        wb_sel_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_cti_i  = CTI_CLASSIC;
        wb_bte_i  = BTE_LINEAR;
        txm_ack   = 1'b0;
        txs_ack   = 1'b0;
        rxm_ack   = 1'b0;
        rxs_ack   = 1'b0;
        sub_dat_i = {32'hA5A5_0001, 32'h5000_0000, 32'h2222_0002, 32'h1111_0001};

        // Reset state
        repeat (3) tick();
        checkOutput("rst_ack",     32'(wb_ack_o),  32'h0);
        checkOutput("rst_err",     32'(wb_err_o),  32'h0);
        checkOutput("rst_stb",     32'(sub_stb_o), 32'h0);
        checkOutput("rst_dat",     wb_dat_o,       32'h0);
        checkOutput("rst_err_cnt", 32'(err_cnt_o), 32'h0);
        checkOutput("rst_sub_dat", sub_dat_o,      32'h0);
        wb_rst_i = 1'b0;
        tick();

        // Write 0x04 -> txm, register 1
        applyStimulus(32'h04, 1'b1, 32'h1234, CTI_CLASSIC, BTE_LINEAR);
        tick();
        checkOutput("wr_stb",     32'(sub_stb_o), 32'h1);
        checkOutput("wr_adr",     32'(sub_adr_o), 32'h1);
        checkOutput("wr_sub_dat", sub_dat_o,      32'h1234);
        checkOutput("wr_we",      32'(sub_we_o),  32'h1);
        checkOutput("wr_no_ack",  32'(wb_ack_o),  32'h0);
        txm_ack = 1'b1;
        tick();
        txm_ack = 1'b0;
        checkOutput("wr_ack",     32'(wb_ack_o),  32'h1);
        checkOutput("wr_dat_o",   wb_dat_o,       32'h0);
        checkOutput("wr_stb_off", 32'(sub_stb_o), 32'h0);
        endCycle();
        tick();
        checkOutput("wr_ack_pulse", 32'(wb_ack_o), 32'h0);

        // Read 0xC8 -> rxs (core 3), register 2; ack three cycles after strobe
        applyStimulus(32'hC8, 1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        checkOutput("rd_stb", 32'(sub_stb_o), 32'h8);
        checkOutput("rd_adr", 32'(sub_adr_o), 32'h2);
        tick();
        checkOutput("rd_wait_ack", 32'(wb_ack_o), 32'h0);
        tick();
        tick();
        rxs_ack = 1'b1;
        tick();
        rxs_ack = 1'b0;
        checkOutput("rd_ack",   32'(wb_ack_o), 32'h1);
        checkOutput("rd_dat_o", wb_dat_o,      32'hA5A5_0001);
        endCycle();
        tick();
        checkOutput("rd_ack_pulse", 32'(wb_ack_o), 32'h0);

        // Decode miss at 0x100
        applyStimulus(32'h100, 1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        checkOutput("miss_stb",     32'(sub_stb_o), 32'h0);
        checkOutput("miss_err",     32'(wb_err_o),  32'h1);
        checkOutput("miss_ack",     32'(wb_ack_o),  32'h0);
        checkOutput("miss_err_cnt", 32'(err_cnt_o), 32'h1);
        endCycle();
        tick();
        checkOutput("miss_err_pulse", 32'(wb_err_o), 32'h0);

        // Timeout on txs while rxm acks continuously
        applyStimulus(32'h40, 1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        checkOutput("to_stb", 32'(sub_stb_o), 32'h2);
        rxm_ack    = 1'b1;
        cyc_n      = 1;
        stb_cycles = 1;
        got_err    = 1'b0;
        got_ack    = 1'b0;
        while (!got_err && !got_ack && cyc_n < 40) begin
            tick();
            cyc_n++;
            if (sub_stb_o == 4'b0010) stb_cycles++;
            got_err = wb_err_o;
            got_ack = wb_ack_o;
        end
        rxm_ack = 1'b0;
        checkOutput("to_err_seen",   32'(got_err),   32'h1);
        checkOutput("to_no_ack",     32'(got_ack),   32'h0);
        checkOutput("to_err_cycle",  cyc_n,          32'd17);
        checkOutput("to_stb_cycles", stb_cycles,     32'd16);
        checkOutput("to_err_cnt",    32'(err_cnt_o), 32'h2);
        endCycle();
        tick();

        // Ack on the terminal count cycle wins over the timeout
        applyStimulus(32'h40, 1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        repeat (16) tick();
        checkOutput("tc_stb_still", 32'(sub_stb_o), 32'h2);
        txs_ack = 1'b1;
        tick();
        txs_ack = 1'b0;
        checkOutput("tc_ack",     32'(wb_ack_o),  32'h1);
        checkOutput("tc_no_err",  32'(wb_err_o),  32'h0);
        checkOutput("tc_dat_o",   wb_dat_o,       32'h2222_0002);
        checkOutput("tc_err_cnt", 32'(err_cnt_o), 32'h2);
        endCycle();
        tick();

        // Cycle abandoned while waiting
        applyStimulus(32'h80, 1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        checkOutput("drop_stb_on", 32'(sub_stb_o), 32'h4);
        endCycle();
        tick();
        checkOutput("drop_stb_off", 32'(sub_stb_o), 32'h0);
        checkOutput("drop_no_ack",  32'(wb_ack_o),  32'h0);
        checkOutput("drop_no_err",  32'(wb_err_o),  32'h0);
        rxm_ack = 1'b1;
        tick();
        rxm_ack = 1'b0;
        checkOutput("drop_late_ack", 32'(wb_ack_o), 32'h0);
        tick();

        // Four-beat incrementing burst to rxm
        ack_count = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h80 + 32'(4 * i), 1'b0, 32'h0,
                          (i == 3) ? CTI_END : CTI_INCR, BTE_LINEAR);
            if (i > 0) tick();
            tick();
            checkOutput($sformatf("burst%0d_stb", i), 32'(sub_stb_o), 32'h4);
            checkOutput($sformatf("burst%0d_adr", i), 32'(sub_adr_o), 32'(i));
            sub_dat_i[95:64] = 32'h5000_0000 + 32'(i);
            rxm_ack = 1'b1;
            tick();
            rxm_ack = 1'b0;
            if (wb_ack_o) ack_count++;
            checkOutput($sformatf("burst%0d_dat", i), wb_dat_o, 32'h5000_0000 + 32'(i));
        end
        endCycle();
        tick();
        checkOutput("burst_acks", ack_count, 32'd4);

        // Wrapping burst type is refused
        applyStimulus(32'h80, 1'b0, 32'h0, CTI_INCR, 2'b01);
        tick();
        checkOutput("bte_err",     32'(wb_err_o),  32'h1);
        checkOutput("bte_stb",     32'(sub_stb_o), 32'h0);
        checkOutput("bte_err_cnt", 32'(err_cnt_o), 32'h3);
        endCycle();
        tick();

        // Reset while a request is outstanding
        applyStimulus(32'h04, 1'b1, 32'h0000_BEEF, CTI_CLASSIC, BTE_LINEAR);
        tick();
        checkOutput("rreq_stb_on", 32'(sub_stb_o), 32'h1);
        wb_rst_i = 1'b1;
        tick();
        checkOutput("rreq_stb",     32'(sub_stb_o), 32'h0);
        checkOutput("rreq_adr",     32'(sub_adr_o), 32'h0);
        checkOutput("rreq_sub_dat", sub_dat_o,      32'h0);
        checkOutput("rreq_we",      32'(sub_we_o),  32'h0);
        checkOutput("rreq_sel",     32'(sub_sel_o), 32'h0);
        checkOutput("rreq_err_cnt", 32'(err_cnt_o), 32'h0);
        checkOutput("rreq_ack",     32'(wb_ack_o),  32'h0);
        checkOutput("rreq_err",     32'(wb_err_o),  32'h0);
        endCycle();
        wb_rst_i = 1'b0;
        tick();

        // Error counter saturates at 255
        for (int n = 0; n < 300; n++) begin
            applyStimulus(32'h100, 1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
            tick();
            endCycle();
            tick();
        end
        checkOutput("err_cnt_sat", 32'(err_cnt_o), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
